// File: rtl/seq_detect_1011.sv
// seq_detect_1011
//   Serial pattern detector for the bit stream coming out of the 2:1 mux.
//   A Mealy FSM looks for "1011". On each detection it emits a registered
//   one-cycle pulse and bumps a saturating match counter.
//
// Parameters
//   OVERLAP     1: a match may share its trailing "1" with the next pattern
//               0: restart from IDLE after a match
//   CNT_W       width of match_count (saturates at all-ones)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     y_in is sampled only on edges where this is high
//   y_in         serial bit from the mux output
//   clr          synchronous clear of FSM, counter and match (beats in_valid)
//   match        registered detection pulse, one cycle wide
//   match_count  detections since reset/clr, saturating
//   state_o      current FSM state code (debug)
module seq_detect_1011 #(
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             y_in,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   detect;

    // Next state assuming the current edge samples y_in; gating by clr and
    // in_valid is applied in the register process.
    always_comb begin
        state_nxt = state;
        detect    = 1'b0;
        case (state)
            IDLE: begin
                if (y_in) state_nxt = S1;
            end
            S1: begin
                if (!y_in) state_nxt = S10;
            end
            S10: begin
                state_nxt = y_in ? S101 : IDLE;
            end
            S101: begin
                if (y_in) begin
                    detect    = 1'b1;
                    // The closing "1" is itself a valid "1" prefix when overlapping.
                    state_nxt = (OVERLAP != 0) ? S1 : IDLE;
                end else begin
                    // "1010" ends in "10", which is still a live prefix.
                    state_nxt = S10;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            match       <= 1'b0;
            match_count <= '0;
        end else if (clr) begin
            state       <= IDLE;
            match       <= 1'b0;
            match_count <= '0;
        end else if (in_valid) begin
            state <= state_nxt;
            match <= detect;
            if (detect && (match_count != CNT_MAX)) begin
                match_count <= match_count + 1'b1;
            end
        end else begin
            match <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seq_detect_1011.sv
// tb_seq_detect_1011
//   Drives three detector instances from one shared stimulus stream:
//     u_ovl : OVERLAP=1, CNT_W=8
//     u_nov : OVERLAP=0, CNT_W=8
//     u_sat : OVERLAP=1, CNT_W=2
//   Each instance is compared every cycle against a bit-history reference
//   model. A directed vector table, hand-written corner sequences and a
//   random stream are applied in turn.
module tb_seq_detect_1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       y_in = 1'b0;
    logic       clr = 1'b0;

    logic       m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [1:0] s0, s1, s2;

    logic       mt [3];
    logic [7:0] ct [3];
    logic [1:0] st [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    seq_detect_1011 #(.OVERLAP(1), .CNT_W(8)) u_ovl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .clr(clr),
        .match(m0), .match_count(c0), .state_o(s0)
    );
    seq_detect_1011 #(.OVERLAP(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .clr(clr),
        .match(m1), .match_count(c1), .state_o(s1)
    );
    seq_detect_1011 #(.OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in), .clr(clr),
        .match(m2), .match_count(c2), .state_o(s2)
    );

    always_comb begin
        mt[0] = m0; mt[1] = m1; mt[2] = m2;
        ct[0] = c0; ct[1] = c1; ct[2] = {6'd0, c2};
        st[0] = s0; st[1] = s1; st[2] = s2;
    end

    // Reference model: remembers the sampled bits since the last restart
    // (reset, clr, or a non-overlapping match) and reports a match when the
    // last four of them read 1011.
    typedef struct {
        logic [3:0]  hist;
        int unsigned len;
        int unsigned cnt;
        bit          m;
    } model_t;

    model_t      mdl  [3];
    bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned maxc [3] = '{255, 255, 3};

    function automatic model_t mreset();
        model_t r;
        r.hist = '0; r.len = 0; r.cnt = 0; r.m = 1'b0;
        return r;
    endfunction

    function automatic model_t mstep(model_t s, bit o, int unsigned mx,
                                     bit v, bit y, bit c);
        model_t r = s;
        r.m = 1'b0;
        if (c) begin
            r = mreset();
        end else if (v) begin
            r.hist = {s.hist[2:0], y};
            if (r.len < 4) r.len++;
            if (r.len == 4 && r.hist == 4'b1011) begin
                r.m = 1'b1;
                if (r.cnt < mx) r.cnt++;
                if (!o) begin
                    r.hist = '0;
                    r.len  = 0;
                end
            end
        end
        return r;
    endfunction

    // Longest tail of the remembered bits that is a prefix of 1011.
    function automatic logic [1:0] msuffix(model_t s);
        if (s.len >= 3 && s.hist[2:0] == 3'b101) return 2'd3;
        if (s.len >= 2 && s.hist[1:0] == 2'b10)  return 2'd2;
        if (s.len >= 1 && s.hist[0] == 1'b1)     return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string name, input int unsigned act,
                         input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d.match", k), int'(mt[k]), int'(mdl[k].m));
            check($sformatf("dut%0d.count", k), int'(ct[k]), mdl[k].cnt);
            check($sformatf("dut%0d.state", k), int'(st[k]), int'(msuffix(mdl[k])));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s dut%0d.match", tag, k), int'(mt[k]), 0);
            check($sformatf("%s dut%0d.count", tag, k), int'(ct[k]), 0);
            check($sformatf("%s dut%0d.state", tag, k), int'(st[k]), 0);
        end
    endtask

    task automatic tick(input bit v, input bit y, input bit c);
        @(negedge clk);
        in_valid = v;
        y_in     = y;
        clr      = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) mdl[k] = mstep(mdl[k], ovl[k], maxc[k], v, y, c);
        #1;
        check_models();
    endtask

    typedef struct {
        bit          v;
        bit          y;
        bit          c;
        bit          em;
        int unsigned ec;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl [$];

    initial begin : main
        int unsigned pulses;
        int unsigned sat_cnt [$];
        int unsigned exp_sat [5] = '{1, 2, 3, 3, 3};
        logic [15:0] sat_bits = 16'b1011011011011011;
        logic [6:0]  ovl_bits = 7'b1011011;
        bit          prev_m;

        for (int k = 0; k < 3; k++) mdl[k] = mreset();

        // Reset state, held across clock edges.
        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset-held");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors for the OVERLAP=1, CNT_W=8 instance.
        // 1011 then 011 (overlap), clr, 1 0 gap gap gap 1 1, clr,
        // 1 0 1 0 1 1 (recovery via S10), clr, 1 0 1 then clr on final 1.
        tbl.push_back('{1, 1, 0, 0, 0, 2'b01});
        tbl.push_back('{1, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b11});
        tbl.push_back('{1, 1, 0, 1, 1, 2'b01});
        tbl.push_back('{1, 0, 0, 0, 1, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 1, 2'b11});
        tbl.push_back('{1, 1, 0, 1, 2, 2'b01});
        tbl.push_back('{1, 0, 1, 0, 0, 2'b00});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b01});
        tbl.push_back('{1, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{0, 1, 0, 0, 0, 2'b10});
        tbl.push_back('{0, 1, 0, 0, 0, 2'b10});
        tbl.push_back('{0, 1, 0, 0, 0, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b11});
        tbl.push_back('{1, 1, 0, 1, 1, 2'b01});
        tbl.push_back('{0, 0, 1, 0, 0, 2'b00});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b01});
        tbl.push_back('{1, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b11});
        tbl.push_back('{1, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b11});
        tbl.push_back('{1, 1, 0, 1, 1, 2'b01});
        tbl.push_back('{0, 0, 1, 0, 0, 2'b00});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b01});
        tbl.push_back('{1, 0, 0, 0, 0, 2'b10});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b11});
        tbl.push_back('{1, 1, 1, 0, 0, 2'b00});
        tbl.push_back('{1, 1, 0, 0, 0, 2'b01});

        foreach (tbl[i]) begin
            tick(tbl[i].v, tbl[i].y, tbl[i].c);
            check($sformatf("vec%0d.match", i), int'(m0), int'(tbl[i].em));
            check($sformatf("vec%0d.count", i), int'(c0), tbl[i].ec);
            check($sformatf("vec%0d.state", i), int'(s0), int'(tbl[i].es));
        end

        // 1011011: two pulses when overlapping, one when not.
        tick(1'b0, 1'b0, 1'b1);
        pulses = 0;
        begin
            int unsigned p1 = 0;
            for (int i = 6; i >= 0; i--) begin
                tick(1'b1, ovl_bits[i], 1'b0);
                if (m0) pulses++;
                if (m1) p1++;
            end
            check("ovl1.pulses", pulses, 2);
            check("ovl1.count", int'(c0), 2);
            check("ovl0.pulses", p1, 1);
            check("ovl0.count", int'(c1), 1);
        end

        // CNT_W=2: five overlapping patterns saturate the count at 3.
        tick(1'b0, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 15; i >= 0; i--) begin
            tick(1'b1, sat_bits[i], 1'b0);
            if (m2) begin
                pulses++;
                sat_cnt.push_back(int'(c2));
            end
        end
        check("sat.pulses", pulses, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < sat_cnt.size()) check($sformatf("sat.count%0d", i), sat_cnt[i], exp_sat[i]);
            else check($sformatf("sat.count%0d missing", i), 0, exp_sat[i]);
        end

        // Asynchronous reset mid-pattern after 1,0,1.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async-rst");
        for (int k = 0; k < 3; k++) mdl[k] = mreset();
        @(posedge clk);
        #1;
        check_zero("rst-held");
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("post-rst.count", int'(c0), 0);

        // Random stream against the reference models.
        prev_m = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(49, 0) == 0);
            if (prev_m) check("no-back-to-back", int'(m0), 0);
            prev_m = m0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
